// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Imported by pipe_ctrl and pipe_perfcnt.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load-use hazard: the EX load writes a register the ID instruction reads.
  function automatic logic load_use_hazard(input logic       memrd,
                                           input logic [4:0] ex_rt,
                                           input logic [4:0] id_rs,
                                           input logic [4:0] id_rt);
    return memrd && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_perfcnt.sv
// Saturating stall-cycle and redirect-cycle counters (build with PIPE_PERF_EN).
// One-cycle update latency; no backpressure, counters simply stop at all-ones.
module pipe_perfcnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_i && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
    if (flush_i && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory hold > redirect > load-use; controls are zero-latency, mem_err registered.
// Memory hold freezes PC/IF/ID/EX/MEM and bubbles MEM/WB; PIPE_PERF_EN adds stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idex_memrd,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       exmem_brtaken,
  input  logic       exmem_jump,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output logic       pc_wr,
  output logic       ifid_wr,
  output logic       exmem_wr,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_bubble,
  output logic       pc_redirect,
  output logic       mem_err,
  output logic [1:0] state
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (TMO_W < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_ctrl: TMO_W must be >= 2 and CNT_W >= 1");
  end

  localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic             mem_err_q, mem_err_d;

  logic memhold, redirect, load_use;

  assign memhold  = dmem_req & ~dmem_ack;
  assign redirect = exmem_brtaken | exmem_jump;
  assign load_use = load_use_hazard(idex_memrd, idex_rt, ifid_rs, ifid_rt);

  // Controls depend only on the live inputs, so an MWAIT cycle that sees the ack behaves as RUN.
  always_comb begin
    pc_wr        = 1'b0;
    ifid_wr      = 1'b0;
    exmem_wr     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst_n) begin
      pc_wr = 1'b0;
    end else if (memhold) begin
      memwb_bubble = 1'b1;
    end else if (redirect) begin
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      exmem_wr    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pc_redirect = 1'b1;
    end else if (load_use) begin
      idex_flush = 1'b1;
      exmem_wr   = 1'b1;
    end else begin
      pc_wr    = 1'b1;
      ifid_wr  = 1'b1;
      exmem_wr = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    mem_err_d = 1'b0;
    case (state_q)
      RUN: begin
        if (memhold) begin
          state_d = MWAIT;
          wdog_d  = '0;
        end
      end
      MWAIT: begin
        if (!memhold) begin
          state_d = RUN;
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = RUN;
          wdog_d    = '0;
          mem_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      default: begin
        state_d = RUN;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wdog_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef PIPE_PERF_EN
  pipe_perfcnt #(
    .CNT_W (CNT_W)
  ) u_perfcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (~pc_wr),
    .flush_i     (pc_redirect),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TMO_W=4 so the watchdog expires quickly).
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_pipe_ctrl;

  localparam int TMO_W = 4;
  localparam int CNT_W = 16;

  logic       clk;
  logic       rst_n;
  logic       idex_memrd;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       exmem_brtaken;
  logic       exmem_jump;
  logic       dmem_req;
  logic       dmem_ack;
  logic       pc_wr, ifid_wr, exmem_wr;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_redirect;
  logic       mem_err;
  logic [1:0] state;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Control bundle: {pc_wr, ifid_wr, exmem_wr, ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_redirect}
  localparam logic [7:0] C_IDLE  = 8'hE0;
  localparam logic [7:0] C_LDUSE = 8'h28;
  localparam logic [7:0] C_REDIR = 8'hFD;
  localparam logic [7:0] C_HOLD  = 8'h02;
  localparam logic [7:0] C_RST   = 8'h00;

  wire [7:0] ctrl = {pc_wr, ifid_wr, exmem_wr, ifid_flush, idex_flush,
                     exmem_flush, memwb_bubble, pc_redirect};

  pipe_ctrl #(
    .TMO_W (TMO_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .idex_memrd    (idex_memrd),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .exmem_brtaken (exmem_brtaken),
    .exmem_jump    (exmem_jump),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .pc_wr         (pc_wr),
    .ifid_wr       (ifid_wr),
    .exmem_wr      (exmem_wr),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .memwb_bubble  (memwb_bubble),
    .pc_redirect   (pc_redirect),
    .mem_err       (mem_err),
    .state         (state)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idex_memrd    = 1'b0;
    idex_rt       = 5'd0;
    ifid_rs       = 5'd0;
    ifid_rt       = 5'd0;
    exmem_brtaken = 1'b0;
    exmem_jump    = 1'b0;
    dmem_req      = 1'b0;
    dmem_ack      = 1'b0;
  endtask

  initial begin
    int errs;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Load-use on rs: stall for one edge
    idex_memrd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
    #1;
    chk("lduse_rs", 32'(ctrl), 32'(C_LDUSE));
    step();
    idle_inputs();
    #1;
    chk("lduse_release", 32'(ctrl), 32'(C_IDLE));

    // r0 destination never stalls
    idex_memrd = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1;
    chk("lduse_r0", 32'(ctrl), 32'(C_IDLE));
    // Non-load with matching registers never stalls
    idex_memrd = 1'b0; idex_rt = 5'd7; ifid_rt = 5'd7;
    #1;
    chk("nonload_match", 32'(ctrl), 32'(C_IDLE));

    // Load-use on rt: second stall edge
    step();
    idex_memrd = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    #1;
    chk("lduse_rt", 32'(ctrl), 32'(C_LDUSE));
    step();
    idle_inputs();

    // Redirect with a concurrent load-use: redirect wins, PC keeps writing
    exmem_brtaken = 1'b1; idex_memrd = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1;
    chk("redir_br_lduse", 32'(ctrl), 32'(C_REDIR));
    chk("redir_pc_wr", 32'(pc_wr), 32'd1);
    step();
    idle_inputs();
    exmem_jump = 1'b1;
    #1;
    chk("redir_jump", 32'(ctrl), 32'(C_REDIR));
    // Memory hold outranks redirect
    dmem_req = 1'b1;
    #1;
    chk("hold_over_redir", 32'(ctrl), 32'(C_HOLD));
    // Acked access is not a hold
    dmem_ack = 1'b1;
    #1;
    chk("req_with_ack", 32'(ctrl), 32'(C_REDIR));
    idle_inputs();
    #1;
    chk("state_run", 32'(state), 32'd0);

`ifdef PIPE_PERF_EN
    step();
    chk("perf_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd1);
`endif

    // Memory wait: ack arrives after three wait cycles
    step();
    dmem_req = 1'b1;
    #1;
    chk("mwait_c0_ctrl", 32'(ctrl), 32'(C_HOLD));
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("mwait_state_%0d", i), 32'(state), 32'd1);
      chk($sformatf("mwait_bubble_%0d", i), 32'(memwb_bubble), 32'd1);
    end
    dmem_ack = 1'b1;
    #1;
    chk("mwait_ack_ctrl", 32'(ctrl), 32'(C_IDLE));
    step();
    chk("mwait_exit_state", 32'(state), 32'd0);
    chk("mwait_no_err", 32'(mem_err), 32'd0);
    idle_inputs();

    // Watchdog: no ack; counter reaches 14 after 15 edges, expiry on the 16th
    step();
    dmem_req = 1'b1;
    errs = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (mem_err) errs++;
    end
    chk("wdog_early_err", 32'(errs), 32'd0);
    chk("wdog_wait_state", 32'(state), 32'd1);
    step();
    chk("wdog_err_pulse", 32'(mem_err), 32'd1);
    chk("wdog_err_state", 32'(state), 32'd0);
    dmem_req = 1'b0;
    step();
    chk("wdog_err_single", 32'(mem_err), 32'd0);
    chk("wdog_after_state", 32'(state), 32'd0);

    // Reset during MWAIT: immediate abandon, no error pulse
    dmem_req = 1'b1;
    step();
    step();
    step();
    chk("rstw_pre_state", 32'(state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_state", 32'(state), 32'd0);
    chk("rstw_ctrl", 32'(ctrl), 32'(C_RST));
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_err) errs++;
    end
    chk("rstw_no_err", 32'(errs), 32'd0);
    dmem_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rstw_release_ctrl", 32'(ctrl), 32'(C_IDLE));
    step();
    chk("rstw_release_state", 32'(state), 32'd0);
    chk("rstw_release_err", 32'(mem_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
